amp_window_detector: RTL and testbench

//   Windowed peak-amplitude detector with hysteresis and confirmation. Sits directly

---
 rtl/amp_window_detector.sv | 169 ++++++++++++++++
 tb/tb_amp_window_detector.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/amp_window_detector.sv
`default_nettype none
// ============================================================================
//  Module   : amp_window_detector
//  Purpose  : Windowed peak-amplitude detector with hysteresis and
//             multi-window confirmation. It consumes the filtered sample
//             stream at the sample-strobe rate, reports the peak |y| of every
//             completed window and raises a detection flag once the amplitude
//             has stayed high for CONFIRM windows. The flag drops once the
//             amplitude has stayed low for CONFIRM windows.
//  Ports    : clk          - system clock
//             rst          - asynchronous, active-high reset
//             clk_en_i     - sample strobe, one clk wide
//             y_i          - signed filter output sample (W bits)
//             peak_o       - peak |y| of last completed window (W-1 bits)
//             peak_valid_o - one-clk pulse when peak_o is refreshed
//             detected_o   - amplitude-present flag
//  Revision : 1.0 - initial release
// ============================================================================
module amp_window_detector #(
  parameter int W       = 16,
  parameter int WIN     = 256,
  parameter int TH_HI   = 2048,
  parameter int TH_LO   = 1024,
  parameter int CONFIRM = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clk_en_i,
  input  logic [W-1:0] y_i,
  output logic [W-2:0] peak_o,
  output logic         peak_valid_o,
  output logic         detected_o
);

  localparam int CW = $clog2(WIN);
  localparam int NW = $clog2(CONFIRM + 1);

  localparam logic [CW-1:0] LAST_IDX = CW'(WIN - 1);
  localparam logic [W-2:0]  HI_TH    = (W-1)'(TH_HI);
  localparam logic [W-2:0]  LO_TH    = (W-1)'(TH_LO);
  localparam logic [NW-1:0] CONF_N   = NW'(CONFIRM);
  localparam logic [NW-1:0] ONE_N    = NW'(1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ARMING    = 2'd1,
    ACTIVE    = 2'd2,
    RELEASING = 2'd3
  } state_t;

  state_t         state_q;
  logic [CW-1:0]  win_cnt_q;
  logic [W-2:0]   run_max_q;
  logic [NW-1:0]  cnt_q;

  logic           is_min_d;
  logic [W-2:0]   mag_d;
  logic [W-2:0]   max_d;
  logic [NW-1:0]  cnt_inc_d;
  logic           win_end_d;
  logic           on_d;
  logic           off_d;

  always_comb begin
    // The most negative sample has no positive W-bit counterpart, so its
    // magnitude saturates to the largest W-1 bit value.
    is_min_d = (y_i == {1'b1, {(W-1){1'b0}}});
    if (is_min_d)
      mag_d = {(W-1){1'b1}};
    else if (y_i[W-1])
      mag_d = ~y_i[W-2:0] + {{(W-2){1'b0}}, 1'b1};
    else
      mag_d = y_i[W-2:0];

    // Max including the current sample: this is the new peak on window end.
    max_d     = (mag_d > run_max_q) ? mag_d : run_max_q;
    on_d      = (max_d >= HI_TH);
    off_d     = (max_d <  LO_TH);
    cnt_inc_d = cnt_q + ONE_N;
    win_end_d = (win_cnt_q == LAST_IDX);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      win_cnt_q    <= '0;
      run_max_q    <= '0;
      cnt_q        <= '0;
      peak_o       <= '0;
      peak_valid_o <= 1'b0;
      detected_o   <= 1'b0;
    end else begin
      peak_valid_o <= 1'b0;
      if (clk_en_i) begin
        if (win_end_d) begin
          win_cnt_q    <= '0;
          run_max_q    <= '0;
          peak_o       <= max_d;
          peak_valid_o <= 1'b1;
          // Detection state only advances on window boundaries, judged on
          // the freshly completed window's peak.
          case (state_q)
            IDLE: begin
              if (on_d) begin
                if (CONFIRM == 1) begin
                  state_q    <= ACTIVE;
                  detected_o <= 1'b1;
                end else begin
                  state_q <= ARMING;
                  cnt_q   <= ONE_N;
                end
              end
            end
            ARMING: begin
              if (on_d) begin
                if (cnt_inc_d == CONF_N) begin
                  state_q    <= ACTIVE;
                  cnt_q      <= '0;
                  detected_o <= 1'b1;
                end else begin
                  cnt_q <= cnt_inc_d;
                end
              end else begin
                state_q <= IDLE;
                cnt_q   <= '0;
              end
            end
            ACTIVE: begin
              // Peaks in the band [TH_LO, TH_HI) keep the flag asserted.
              if (off_d) begin
                if (CONFIRM == 1) begin
                  state_q    <= IDLE;
                  detected_o <= 1'b0;
                end else begin
                  state_q <= RELEASING;
                  cnt_q   <= ONE_N;
                end
              end
            end
            RELEASING: begin
              if (off_d) begin
                if (cnt_inc_d == CONF_N) begin
                  state_q    <= IDLE;
                  cnt_q      <= '0;
                  detected_o <= 1'b0;
                end else begin
                  cnt_q <= cnt_inc_d;
                end
              end else begin
                state_q <= ACTIVE;
                cnt_q   <= '0;
              end
            end
            default: begin
              state_q    <= IDLE;
              cnt_q      <= '0;
              detected_o <= 1'b0;
            end
          endcase
        end else begin
          win_cnt_q <= win_cnt_q + 1'b1;
          run_max_q <= max_d;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_amp_window_detector.sv
`default_nettype none
// ============================================================================
//  Module   : tb_amp_window_detector
//  Purpose  : Self-checking bench for amp_window_detector with WIN=4,
//             CONFIRM=2, TH_HI=2048, TH_LO=1024 and a sample strobe every
//             fourth clock. Table of per-sample vectors plus hand-written
//             sequences for strobe-hold and mid-window reset.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_amp_window_detector;

  localparam int W = 16;

  logic         clk;
  logic         rst;
  logic         clk_en;
  logic [W-1:0] y;
  logic [W-2:0] peak;
  logic         peak_valid;
  logic         detected;

  int total;
  int bad;

  typedef struct {
    logic [W-1:0] y;
    logic [W-2:0] peak;
    logic         pv;
    logic         det;
  } vec_t;

  vec_t tab[$];

  amp_window_detector #(
    .W(W), .WIN(4), .TH_HI(2048), .TH_LO(1024), .CONFIRM(2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .clk_en_i     (clk_en),
    .y_i          (y),
    .peak_o       (peak),
    .peak_valid_o (peak_valid),
    .detected_o   (detected)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One accepted sample: strobe for one clk, check on the following
  // negedge, confirm the valid pulse has ended one clk later, then idle
  // with random y so that every fourth clk carries the strobe.
  task automatic do_sample(input logic [W-1:0] yv, input int ep, input int epv,
                           input int edet, input string name);
    @(negedge clk);
    y      = yv;
    clk_en = 1'b1;
    @(negedge clk);
    clk_en = 1'b0;
    y      = W'($urandom);
    chk({name, ".peak"}, int'(peak), ep);
    chk({name, ".pv"}, int'(peak_valid), epv);
    chk({name, ".det"}, int'(detected), edet);
    @(negedge clk);
    y = W'($urandom);
    chk({name, ".pv_end"}, int'(peak_valid), 0);
    @(negedge clk);
    y = W'($urandom);
  endtask

  // Pushes one window of four samples: peak/det hold their previous values
  // on the first three samples and update on the fourth.
  function automatic void add_win(input int a, input int b, input int c, input int d,
                                  input int pp, input int np, input int pd, input int nd);
    vec_t v;
    int   s[4];
    s = '{a, b, c, d};
    for (int i = 0; i < 4; i++) begin
      v.y    = W'(s[i]);
      v.peak = (W-1)'((i == 3) ? np : pp);
      v.pv   = (i == 3);
      v.det  = (i == 3) ? nd[0] : pd[0];
      tab.push_back(v);
    end
  endfunction

  initial begin
    total  = 0;
    bad    = 0;
    rst    = 1'b1;
    clk_en = 1'b0;
    y      = '0;

    // Steady high amplitude: ARMING after window 1, ACTIVE after window 2.
    add_win(4096, 4096, 4096, 4096, 0,    4096, 0, 0);
    add_win(4096, 4096, 4096, 4096, 4096, 4096, 0, 1);
    // Hysteresis band holds ACTIVE for ten windows.
    add_win(1500, 1500, 1500, 1500, 4096, 1500, 1, 1);
    for (int k = 0; k < 9; k++)
      add_win(1500, 1500, 1500, 1500, 1500, 1500, 1, 1);
    // One low window -> RELEASING, a band window -> ACTIVE, two low -> IDLE.
    add_win(500,  500,  500,  500,  1500, 500,  1, 1);
    add_win(1100, 1100, 1100, 1100, 500,  1100, 1, 1);
    add_win(500,  500,  500,  500,  1100, 500,  1, 1);
    add_win(500,  500,  500,  500,  500,  500,  1, 0);
    // Most negative sample saturates to 32767 and arms the detector.
    add_win(0, -32768, 0, 0,        500,   32767, 0, 0);
    add_win(0, 0, 0, 0,             32767, 0,     0, 0);
    // Peak exactly TH_HI (via a negative sample) qualifies as on.
    add_win(-2048, 100, -5, 7,      0,    2048, 0, 0);
    add_win(2048, 2047, 0, 0,       2048, 2048, 0, 1);
    // Peak exactly TH_LO is not low; TH_LO-1 is.
    add_win(1024, 1024, 1024, 1024, 2048, 1024, 1, 1);
    add_win(1023, -1023, 0, 1,      1024, 1023, 1, 1);
    add_win(3000, 10, -20, 5,       1023, 3000, 1, 1);
    add_win(1023, 1023, 1023, 1023, 3000, 1023, 1, 1);
    add_win(-1023, 0, -1023, 0,     1023, 1023, 1, 0);

    repeat (3) @(negedge clk);
    chk("reset.peak", int'(peak), 0);
    chk("reset.pv", int'(peak_valid), 0);
    chk("reset.det", int'(detected), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < tab.size(); i++)
      do_sample(tab[i].y, int'(tab[i].peak), int'(tab[i].pv), int'(tab[i].det),
                $sformatf("vec%0d", i));

    // Strobe low: wild y must not advance the window or the running max.
    do_sample(16'd700, 1023, 0, 0, "hold.s1");
    do_sample(16'd300, 1023, 0, 0, "hold.s2");
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      y = (i % 2 == 0) ? 16'h7FFF : 16'h8000;
      chk("hold.pv", int'(peak_valid), 0);
      chk("hold.peak", int'(peak), 1023);
    end
    do_sample(16'd100, 1023, 0, 0, "hold.s3");
    do_sample(16'd200, 700,  1, 0, "hold.s4");

    // Mid-window reset while ACTIVE discards the partial window.
    for (int i = 0; i < 8; i++)
      do_sample(16'd4096, (i < 3) ? 700 : 4096, (i == 3 || i == 7) ? 1 : 0,
                (i == 7) ? 1 : 0, "rst.pre");
    do_sample(16'd4096, 4096, 0, 1, "rst.a1");
    do_sample(16'd4096, 4096, 0, 1, "rst.a2");
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst.det", int'(detected), 0);
    chk("rst.peak", int'(peak), 0);
    chk("rst.pv", int'(peak_valid), 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++)
      do_sample(16'd4096, (i == 3) ? 4096 : 0, (i == 3) ? 1 : 0, 0, "rst.post");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
